// File: rtl/lamp_ctrl_checker.sv
// Lamp controller checker: walks the 3-bit switch code 0..7, holds each code
// for DWELL cycles, samples the returned lamp output F on the last cycle of
// each dwell and compares it with the odd parity of the code.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, switches at 000, waiting for start
// DRIVE | driving code, timing the dwell, sampling F at terminal count
// DONE  | run finished, results held, switches at 000, waiting for start
module lamp_ctrl_checker #(
   parameter int unsigned DWELL = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       S1,
   output logic       S2,
   output logic       S3,
   input  logic       F,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [7:0] result,
   output logic [2:0] first_fail
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [15:0] TIMER_LAST = 16'(DWELL - 1);
   localparam logic [3:0]  ERR_MAX    = 4'd8;

   state_e      state_q, state_d;
   logic [2:0]  code_q, code_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  err_cnt_q, err_cnt_d;
   logic [7:0]  result_q, result_d;
   logic [2:0]  first_fail_q, first_fail_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        mismatch;

   // State and result registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         code_q       <= 3'd0;
         timer_q      <= 16'd0;
         err_cnt_q    <= 4'd0;
         result_q     <= 8'd0;
         first_fail_q <= 3'd0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         timer_q      <= timer_d;
         err_cnt_q    <= err_cnt_d;
         result_q     <= result_d;
         first_fail_q <= first_fail_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   // Next-state: start handling, dwell timing and the per-code F comparison.
   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      timer_d      = timer_q;
      err_cnt_d    = err_cnt_q;
      result_d     = result_q;
      first_fail_d = first_fail_q;
      done_d       = done_q;
      pass_d       = pass_q;
      mismatch     = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = DRIVE;
               code_d       = 3'd0;
               timer_d      = 16'd0;
               err_cnt_d    = 4'd0;
               result_d     = 8'd0;
               first_fail_d = 3'd0;
               done_d       = 1'b0;
               pass_d       = 1'b0;
            end
         end
         DRIVE: begin
            timer_d = timer_q + 16'd1;
            if (timer_q == TIMER_LAST) begin
               mismatch = (F != (^code_q));
               if (!mismatch) begin
                  result_d[code_q] = 1'b1;
               end else begin
                  if (err_cnt_q != ERR_MAX)
                     err_cnt_d = err_cnt_q + 4'd1;
                  if (err_cnt_q == 4'd0)
                     first_fail_d = code_q;
               end
               if (code_q != 3'd7) begin
                  code_d  = code_q + 3'd1;
                  timer_d = 16'd0;
               end else begin
                  // pass uses the count including this last sample
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == 4'd0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Switch drives are the registered code, gated to 000 outside DRIVE.
   always_comb begin
      busy         = (state_q == DRIVE);
      {S1, S2, S3} = busy ? code_q : 3'b000;
   end

   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign result     = result_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_lamp_ctrl_checker.sv
// Bench for lamp_ctrl_checker: a DWELL=4 instance driven by a modelled lamp
// controller with selectable faulty codes, scored through an expectation
// queue, plus a DWELL=2 instance used for the per-code dwell timing check.
module tb_lamp_ctrl_checker;

   localparam int D4 = 4;
   localparam int D2 = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       S1, S2, S3, F;
   logic       busy, done, pass;
   logic [3:0] err_cnt;
   logic [7:0] result;
   logic [2:0] first_fail;

   logic       start2 = 1'b0;
   logic       a1, a2, a3, f2;
   logic       busy2, done2, pass2;
   logic [3:0] err_cnt2;
   logic [7:0] result2;
   logic [2:0] first_fail2;

   logic [7:0] fault_mask = 8'h00;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;

   typedef struct {
      int         t_done;
      logic [7:0] res;
      logic [3:0] ec;
      logic [2:0] ff;
      logic       ps;
   } exp_t;

   exp_t sb[$];

   lamp_ctrl_checker #(.DWELL(D4)) u_d4 (
      .clk(clk), .rst(rst), .start(start),
      .S1(S1), .S2(S2), .S3(S3), .F(F),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .result(result), .first_fail(first_fail)
   );

   lamp_ctrl_checker #(.DWELL(D2)) u_d2 (
      .clk(clk), .rst(rst), .start(start2),
      .S1(a1), .S2(a2), .S3(a3), .F(f2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err_cnt2), .result(result2), .first_fail(first_fail2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Lamp controller models: correct parity, optionally wrong on masked codes.
   always_comb begin
      F  = (^{S1, S2, S3}) ^ fault_mask[{S1, S2, S3}];
      f2 = ^{a1, a2, a3};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: a code fails exactly when the controller's F differs from
   // the parity of the code, i.e. where the fault mask bit is set.
   function automatic exp_t model(input logic [7:0] mask, input int t_start);
      exp_t e;
      int   fails;
      fails   = 0;
      e.ff    = 3'd0;
      for (int c = 7; c >= 0; c--) begin
         if (mask[c]) begin
            fails++;
            e.ff = 3'(c);
         end
      end
      e.res    = ~mask;
      e.ec     = 4'(fails);
      e.ps     = (fails == 0);
      e.t_done = t_start + 8 * D4;
      return e;
   endfunction

   // Monitor: on each rising done, pop the oldest expectation and compare.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(cyc), 32'(e.t_done));
               chk("err_cnt", 32'(err_cnt), 32'(e.ec));
               chk("result", 32'(result), 32'(e.res));
               chk("pass", 32'(pass), 32'(e.ps));
               if (!e.ps) chk("first_fail", 32'(first_fail), 32'(e.ff));
               chk("idle_S_busy", {28'd0, S1, S2, S3, busy}, 32'd0);
            end
         end
         done_prev = done;
      end
   end

   task automatic pulse_start(output int t_start);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t_start = cyc;
   endtask

   task automatic run(input logic [7:0] mask, input bit repulse);
      int   t0;
      int   n;
      exp_t e;
      fault_mask = mask;
      pulse_start(t0);
      e = model(mask, t0);
      sb.push_back(e);
      chk("busy_after_start", 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 8 * D4 + 10) begin
         if (repulse && n == 6) start = 1'b1;
         else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!done) fail_now("timeout_waiting_done");
      repeat (3) @(negedge clk);
      chk("hold_result", 32'(result), 32'(e.res));
      chk("hold_err_cnt", 32'(err_cnt), 32'(e.ec));
      chk("hold_done", 32'(done), 32'd1);
   endtask

   initial begin
      int t0;
      // Reset state while rst is held.
      #1;
      chk("reset_outputs",
          {9'd0, S1, S2, S3, busy, done, pass, err_cnt, result, first_fail}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Correct controller, stuck-at-0, inverted parity.
      run(8'h00, 1'b0);
      run(8'h96, 1'b0);
      run(8'hFF, 1'b0);

      // Re-pulsed start during DRIVE is ignored; latency still 8*DWELL.
      run(8'h00, 1'b1);

      // Random fault patterns; each start out of DONE starts a fresh run.
      for (int i = 0; i < 6; i++) run(8'($urandom_range(0, 255)), 1'b0);

      // Reset mid-run: asynchronous clear, then wait for a new start.
      fault_mask = 8'hFF;
      pulse_start(t0);
      repeat (10) @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      chk("pre_reset_err_cnt", 32'(err_cnt), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {9'd0, S1, S2, S3, busy, done, pass, err_cnt, result, first_fail}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_idle", {30'd0, busy, done}, 32'd0);
      run(8'h00, 1'b0);

      // Per-code dwell on the DWELL=2 instance.
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int j = 0; j < 8 * D2; j++) begin
         chk("dwell_S", {29'd0, a1, a2, a3}, 32'(j / D2));
         @(negedge clk);
      end
      chk("dwell_done", {29'd0, done2, pass2, busy2}, 32'b110);
      chk("dwell_result", 32'(result2), 32'hFF);

      repeat (4) @(negedge clk);
      if (sb.size() != 0) fail_now("expectations_left_unchecked");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_expired");
      $fatal(1, "bench did not finish");
   end

endmodule
